pipe_ctrl_unit: RTL
===================

Name: pipe_ctrl_unit

Overview:
- Second-generation control unit for the 5-stage RISC-V pipeline.
- Decodes the ID-stage instruction and registers its control word into the ID/EX control latch.
- Detects load-use hazards and inserts bubbles.
- Resolves BEQ in ID and flushes IF/ID only when the branch is taken.
- Sequences an optional multi-cycle MUL that holds the pipe for a parametrised latency.

Parameters:
- ALUOP_W, 2: ALUOp width; must be >=2.
- MUL_EN, 1: 1 decodes R-type with funct7=0000001 as MUL.
- MUL_LAT, 4: MUL EX occupancy in cycles; range 1..15.
- BRANCH_FLUSH, 1: flush_o cycles per taken branch; 1 or 2.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  synchronous reset, active-high.
- valid_i  in  1  ID holds a real instruction.
- Op_i  in  7  ID opcode.
- Funct7_i  in  7  ID funct7.
- RS1addr_i  in  5  ID rs1.
- RS2addr_i  in  5  ID rs2.
- RDaddr_i  in  5  ID rd.
- RegEqual_i  in  1  rs1 data == rs2 data, from ID comparator.
- MemWrite_o  out  1  registered EX control.
- MemRead_o  out  1  registered EX control.
- MemToReg_o  out  1  registered EX control.
- ALUOp_o  out  ALUOP_W  registered EX control.
- ALUSrc_o  out  1  registered EX control.
- RegWrite_o  out  1  registered EX control.
- EX_RDaddr_o  out  5  registered rd of the EX instruction.
- stall_o  out  1  hold PC and IF/ID; combinational.
- flush_o  out  1  zero IF/ID; combinational from state and ID inputs.
- branch_taken_o  out  1  select branch target for PC; combinational.
- illegal_o  out  1  registered one-cycle pulse for an unknown opcode.

Behaviour:
- Decode, zero-extended to ALUOP_W:
  - 0110011: ALUOp 10, RegWrite.
  - 0010011: ALUOp 00, ALUSrc, RegWrite.
  - 0000011: ALUOp 00, ALUSrc, MemRead, MemToReg, RegWrite.
  - 0100011: ALUOp 00, ALUSrc, MemWrite.
  - 1100011 (BEQ): ALUOp 01, no writes.
  - MUL (MUL_EN=1): ALUOp 11, RegWrite.
  - Any other opcode: all zero, and illegal_o pulses next cycle if valid_i.
- Reset: all registered outputs 0, EX_RDaddr_o=0, state RUN, counter 0. Reset asserted mid-MUL or mid-flush aborts at the next edge; comb outputs are 0 while rst_i=1.
- Latency: the control word appears on the EX outputs 1 cycle after the instruction is in ID with no stall.
- States:
  - RUN:
    - If valid_i=0, the EX latch takes a bubble (all zero).
    - Load-use: MemRead_o=1 AND EX_RDaddr_o!=0 AND (EX_RDaddr_o==RS1addr_i OR (EX_RDaddr_o==RS2addr_i AND Op is R/store/BEQ)). Then stall_o=1, EX latch takes a bubble, branch_taken_o=0 and flush_o=0 this cycle. Stay in RUN; the dependent instruction is re-evaluated next cycle.
    - Else BEQ with RegEqual_i=1: branch_taken_o=1, flush_o=1, EX takes a bubble. If BRANCH_FLUSH=2, go to FLUSH.
    - Else BEQ not taken: no flush; the BEQ's no-write control word enters EX.
    - Else MUL with MUL_LAT>1: latch the MUL control word, load counter=MUL_LAT-1, go to MULBUSY.
  - MULBUSY:
    - stall_o=1; EX latch and EX_RDaddr_o hold; flush_o=0; branch_taken_o=0.
    - Decrement the counter each cycle; when it reaches 1, go to RUN.
    - Gives exactly MUL_LAT-1 stall cycles. MUL_LAT=1 behaves as a normal R-type.
  - FLUSH:
    - flush_o=1, stall_o=0, EX takes a bubble; RUN next cycle.
    - Hazard checks are suppressed because the ID instruction is being discarded.
- Priority: reset > MULBUSY > FLUSH > load-use > taken branch > normal issue.
- Comparisons use only registered EX fields. rd=x0 never creates a hazard.

Test Plan:
- Reset, then add x3,x1,x2 (valid_i=1) -> next cycle RegWrite_o=1, ALUOp_o=10, ALUSrc_o=0, EX_RDaddr_o=3, stall_o=0.
- lw x5,0(x1) then add x6,x5,x2 -> stall_o=1 for exactly 1 cycle, all-zero bubble in EX, then add control with RegWrite_o=1. Repeat with lw x0 -> no stall.
- beq, RegEqual_i=1, BRANCH_FLUSH=1 -> branch_taken_o=1 and flush_o=1 for 1 cycle, EX bubble. With BRANCH_FLUSH=2 -> flush_o=1 for 2 cycles. RegEqual_i=0 -> flush_o=0, ALUOp_o=01.
- mul (funct7=0000001), MUL_LAT=4 -> ALUOp_o=11 held for 4 cycles, stall_o=1 for 3 cycles. With MUL_EN=0 -> decoded as plain R-type, no stall.
- rst_i asserted on 2nd MULBUSY cycle -> next edge: all outputs 0, stall_o=0, state RUN.
- Opcode 1111111 with valid_i=1 -> illegal_o=1 for 1 cycle, all EX controls 0. Same opcode with valid_i=0 -> illegal_o=0.

Source files
------------

// File: rtl/pipe_ctrl_unit.sv
// pipe_ctrl_unit: ID decode into the ID/EX control latch, load-use stalls, BEQ flush and multi-cycle MUL hold
module pipe_ctrl_unit #(
   parameter int ALUOP_W      = 2,
   parameter bit MUL_EN       = 1'b1,
   parameter int MUL_LAT      = 4,
   parameter int BRANCH_FLUSH = 1
) (
   input  logic               clk_i,
   input  logic               rst_i,
   input  logic               valid_i,
   input  logic [6:0]         Op_i,
   input  logic [6:0]         Funct7_i,
   input  logic [4:0]         RS1addr_i,
   input  logic [4:0]         RS2addr_i,
   input  logic [4:0]         RDaddr_i,
   input  logic               RegEqual_i,
   output logic               MemWrite_o,
   output logic               MemRead_o,
   output logic               MemToReg_o,
   output logic [ALUOP_W-1:0] ALUOp_o,
   output logic               ALUSrc_o,
   output logic               RegWrite_o,
   output logic [4:0]         EX_RDaddr_o,
   output logic               stall_o,
   output logic               flush_o,
   output logic               branch_taken_o,
   output logic               illegal_o
);
   localparam logic [6:0] OP_R   = 7'b0110011;
   localparam logic [6:0] OP_I   = 7'b0010011;
   localparam logic [6:0] OP_LD  = 7'b0000011;
   localparam logic [6:0] OP_ST  = 7'b0100011;
   localparam logic [6:0] OP_BEQ = 7'b1100011;
   localparam logic [3:0] MUL_CNT = 4'(MUL_LAT - 1);

   typedef enum logic [1:0] {RUN, MULBUSY, FLUSH} state_t;

   typedef struct packed {
      logic               mem_write;
      logic               mem_read;
      logic               mem_to_reg;
      logic [ALUOP_W-1:0] alu_op;
      logic               alu_src;
      logic               reg_write;
   } ctrl_t;

   state_t     state_q, state_d;
   logic [3:0] cnt_q, cnt_d;
   ctrl_t      ex_q, ex_d, dec;
   logic [4:0] ex_rd_q, ex_rd_d;
   logic       illegal_q, illegal_d;
   logic       known, is_mul, uses_rs2, hazard, taken, stall, flush, br_taken;

   // decode the ID opcode into a control word; unknown opcodes leave it zero
   always_comb begin
      dec    = '0;
      known  = 1'b1;
      is_mul = MUL_EN && Op_i == OP_R && Funct7_i == 7'b0000001;
      case (Op_i)
         OP_R:    begin dec.alu_op = is_mul ? ALUOP_W'(3) : ALUOP_W'(2); dec.reg_write = 1'b1; end
         OP_I:    begin dec.alu_src = 1'b1; dec.reg_write = 1'b1; end
         OP_LD:   begin dec.alu_src = 1'b1; dec.mem_read = 1'b1; dec.mem_to_reg = 1'b1; dec.reg_write = 1'b1; end
         OP_ST:   begin dec.alu_src = 1'b1; dec.mem_write = 1'b1; end
         OP_BEQ:  dec.alu_op = ALUOP_W'(1);
         default: known = 1'b0;
      endcase
   end

   // pipeline sequencing: MUL hold, extra flush cycle, load-use bubble, taken branch, normal issue
   always_comb begin
      uses_rs2  = Op_i == OP_R || Op_i == OP_ST || Op_i == OP_BEQ;
      hazard    = valid_i && ex_q.mem_read && ex_rd_q != 5'd0 &&
                  (ex_rd_q == RS1addr_i || (ex_rd_q == RS2addr_i && uses_rs2));
      taken     = valid_i && Op_i == OP_BEQ && RegEqual_i;
      state_d   = state_q;
      cnt_d     = cnt_q;
      ex_d      = ex_q;
      ex_rd_d   = ex_rd_q;
      illegal_d = 1'b0;
      stall     = 1'b0;
      flush     = 1'b0;
      br_taken  = 1'b0;
      if (state_q == MULBUSY) begin
         stall   = 1'b1;
         cnt_d   = cnt_q - 4'd1;
         state_d = cnt_q == 4'd1 ? RUN : MULBUSY;
      end else if (state_q == FLUSH) begin
         flush   = 1'b1;
         ex_d    = '0;
         ex_rd_d = '0;
         state_d = RUN;
      end else if (hazard) begin
         stall   = 1'b1;
         ex_d    = '0;
         ex_rd_d = '0;
      end else if (taken) begin
         flush    = 1'b1;
         br_taken = 1'b1;
         ex_d     = '0;
         ex_rd_d  = '0;
         state_d  = BRANCH_FLUSH == 2 ? FLUSH : RUN;
      end else if (!valid_i || !known) begin
         ex_d      = '0;
         ex_rd_d   = '0;
         illegal_d = valid_i;
      end else begin
         ex_d    = dec;
         ex_rd_d = RDaddr_i;
         if (is_mul && MUL_LAT > 1) begin
            cnt_d   = MUL_CNT;
            state_d = MULBUSY;
         end
      end
   end

   // ID/EX control latch, sequencing state and illegal pulse
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q   <= RUN;
         cnt_q     <= '0;
         ex_q      <= '0;
         ex_rd_q   <= '0;
         illegal_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         ex_q      <= ex_d;
         ex_rd_q   <= ex_rd_d;
         illegal_q <= illegal_d;
      end
   end

   assign MemWrite_o     = ex_q.mem_write;
   assign MemRead_o      = ex_q.mem_read;
   assign MemToReg_o     = ex_q.mem_to_reg;
   assign ALUOp_o        = ex_q.alu_op;
   assign ALUSrc_o       = ex_q.alu_src;
   assign RegWrite_o     = ex_q.reg_write;
   assign EX_RDaddr_o    = ex_rd_q;
   assign illegal_o      = illegal_q;
   assign stall_o        = stall && !rst_i;
   assign flush_o        = flush && !rst_i;
   assign branch_taken_o = br_taken && !rst_i;
endmodule
